// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the digit-serial adder: FSM state encoding and a
// ceil(log2) helper used to size the step counter.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

  // ceil(log2(n)), never less than 1 so a single-step counter still exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// full_adder / digit_adder
// digit_adder is a combinational ripple chain of DIGIT full adders.
//   a, b      : DIGIT-bit addends
//   cin       : carry into bit 0
//   sum       : DIGIT-bit sum
//   cout      : carry out of the digit MSB
//   c_msb_in  : carry into the digit MSB (used for two's-complement overflow)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Multi-cycle adder: adds two WIDTH-bit operands DIGIT bits per clock with a
// registered carry, using a start/busy/done handshake.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, sampled only when not busy
//   a, b, cin : operands, captured on the accepted start edge
//   busy      : high while the operation runs
//   done      : one-cycle pulse after the result registers update
//   sum, cout : result and unsigned carry-out, held until next completion
//   ovf       : two's-complement overflow of the completed addition
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = clog2_min1(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic [WIDTH-1:0] psum_next;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a       (a_sr_q[DIGIT-1:0]),
    .b       (b_sr_q[DIGIT-1:0]),
    .cin     (carry_q),
    .sum     (dsum),
    .cout    (dcout),
    .c_msb_in(dcmsb)
  );

  // New digit enters at the top; after STEPS shifts the register holds the
  // complete sum with digit 0 in the LSBs.
  assign psum_next = (psum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE behaves like IDLE so a held start runs back-to-back.
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> DIGIT;
        b_sr_d  = b_sr_q >> DIGIT;
        psum_d  = psum_next;
        carry_d = dcout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = psum_next;
          cout_d  = dcout;
          ovf_d   = dcmsb ^ dcout;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic [3:0] start_v;
  logic [7:0] a, b;
  logic       cin;
  logic [3:0] busy_v, done_v, cout_v, ovf_v;
  logic [7:0] sum_v [4];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]));

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition with signed-overflow rule.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v, t};
  endfunction

  // Wait for done on instance k counting busy cycles; bounded.
  task automatic wait_done(input int k, output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    while (done_v[k] !== 1'b1 && guard < 40) begin
      if (busy_v[k] === 1'b1) nbusy++;
      tick();
      guard++;
    end
    if (guard >= 40) check($sformatf("timeout_d%0d", k), 32'd0, 32'd1);
  endtask

  task automatic do_op(input int k, input logic [7:0] x, input logic [7:0] y,
                       input logic c, input string tag, input bit full);
    logic [9:0] m;
    int nb;
    int steps;
    steps = 8 >> k;
    m = model(x, y, c);
    a = x; b = y; cin = c;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    wait_done(k, nb);
    if (full) check({tag, "_busy_cycles"}, nb, steps);
    check({tag, "_sum"},  {24'd0, sum_v[k]}, {24'd0, m[7:0]});
    check({tag, "_cout"}, {31'd0, cout_v[k]}, {31'd0, m[8]});
    check({tag, "_ovf"},  {31'd0, ovf_v[k]}, {31'd0, m[9]});
    tick();
    if (full) check({tag, "_done_pulse"}, {31'd0, done_v[k]}, 32'd0);
  endtask

  initial begin
    logic [9:0] m1, m2;
    int nb;
    int gap;
    bit saw_done;

    rst = 1'b1; start_v = '0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_busy_d%0d", k), {31'd0, busy_v[k]}, 32'd0);
      check($sformatf("reset_done_d%0d", k), {31'd0, done_v[k]}, 32'd0);
      check($sformatf("reset_sum_d%0d", k),  {24'd0, sum_v[k]}, 32'd0);
      check($sformatf("reset_cout_d%0d", k), {31'd0, cout_v[k]}, 32'd0);
      check($sformatf("reset_ovf_d%0d", k),  {31'd0, ovf_v[k]}, 32'd0);
    end

    // Directed operands, bit-serial.
    do_op(0, 8'h3C, 8'h0F, 1'b0, "d1_3c_0f", 1'b1);
    do_op(0, 8'hFF, 8'h01, 1'b0, "d1_ff_01", 1'b1);
    do_op(0, 8'h7F, 8'h01, 1'b0, "d1_7f_01", 1'b1);
    do_op(0, 8'hFF, 8'hFF, 1'b1, "d1_ff_ff_c", 1'b1);
    do_op(2, 8'h99, 8'h77, 1'b1, "d4_99_77_c", 1'b1);
    do_op(3, 8'h80, 8'h80, 1'b0, "d8_80_80", 1'b1);
    do_op(1, 8'h55, 8'hAA, 1'b1, "d2_55_aa_c", 1'b1);

    // Start re-asserted mid-run with other operands: ignored.
    m1 = model(8'h12, 8'h34, 1'b1);
    a = 8'h12; b = 8'h34; cin = 1'b1; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(); tick();
    a = 8'hF0; b = 8'hF0; cin = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, nb);
    check("ignore_busy_cycles", nb + 3, 8);
    check("ignore_sum",  {24'd0, sum_v[0]}, {24'd0, m1[7:0]});
    check("ignore_cout", {31'd0, cout_v[0]}, {31'd0, m1[8]});
    tick();

    // Back-to-back: start held through DONE.
    m1 = model(8'hA5, 8'h3B, 1'b0);
    m2 = model(8'h40, 8'h40, 1'b0);
    a = 8'hA5; b = 8'h3B; cin = 1'b0; start_v[0] = 1'b1;
    tick();
    a = 8'h40; b = 8'h40;
    wait_done(0, nb);
    check("b2b_first_sum", {24'd0, sum_v[0]}, {24'd0, m1[7:0]});
    tick();
    start_v[0] = 1'b0;
    gap = 1;
    check("b2b_restart_busy", {31'd0, busy_v[0]}, 32'd1);
    check("b2b_done_drops",   {31'd0, done_v[0]}, 32'd0);
    check("b2b_sum_held",     {24'd0, sum_v[0]}, {24'd0, m1[7:0]});
    while (done_v[0] !== 1'b1 && gap < 40) begin
      tick();
      gap++;
    end
    check("b2b_done_gap", gap, 9);
    check("b2b_second_sum", {24'd0, sum_v[0]}, {24'd0, m2[7:0]});
    check("b2b_second_ovf", {31'd0, ovf_v[0]}, {31'd0, m2[9]});
    tick();

    // Reset in the middle of a run aborts it.
    a = 8'h11; b = 8'h22; cin = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy_v[0]}, 32'd0);
    check("rst_mid_done", {31'd0, done_v[0]}, 32'd0);
    check("rst_mid_sum",  {24'd0, sum_v[0]}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done_v[0] === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("rst_mid_no_done", {31'd0, saw_done}, 32'd0);
    do_op(0, 8'h11, 8'h22, 1'b0, "rst_fresh", 1'b1);

    // Random sweep for every digit size.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 1000; n++) begin
        do_op(k, 8'($urandom), 8'($urandom), 1'($urandom),
              $sformatf("rand_d%0d", 1 << k), (n % 50) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
